// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshake, registered result/flags
// and an iterative signed shift-add multiplier (one multiplier bit per clock).
//
// Ports:
//   clk, reset_n            rising-edge clock, async active-low reset
//   in_valid / in_ready     operand handshake; A, B, cntrl, shiftdir sampled on transfer
//   out_valid / out_ready   result handshake; result, negative, zero, overflow, carry_out
//   busy                    high while a multiply is in progress
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             shiftdir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of 2 and >= 8");
  end

  localparam logic [2:0] OP_PASS  = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;
  logic               ov_q, ov_d;

  logic               accept;
  logic               sub;
  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [WIDTH:0]     a_ext, b_ext;
  logic [WIDTH:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               wr;
  logic [WIDTH-1:0]   new_res;
  logic               new_v;
  logic               new_c;

  assign in_ready  = (state_q == S_IDLE) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

  // Magnitudes need W+1 bits so the most-negative operand is exact.
  assign a_ext = {A[WIDTH-1], A};
  assign b_ext = {B[WIDTH-1], B};
  assign a_mag = A[WIDTH-1] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
  assign b_mag = B[WIDTH-1] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
  assign prod  = sign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_comb begin
    sub     = (cntrl == OP_SUB);
    b_op    = sub ? ~B : B;
    sum_w   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    unique case (cntrl)
      OP_PASS:  alu_res = B;
      OP_SHIFT: alu_res = shiftdir ? (A >> B[SHW-1:0])
                                   : (A << B[SHW-1:0]);
      OP_ADD, OP_SUB: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_XOR:   alu_res = A ^ B;
      OP_MUL:   alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    res_d    = res_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    wr       = 1'b0;
    new_res  = '0;
    new_v    = 1'b0;
    new_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cntrl == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, a_mag};
            mplier_d = b_mag;
            sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
          end else begin
            wr      = 1'b1;
            new_res = alu_res;
            new_v   = alu_v;
            new_c   = alu_c;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!ov_q || out_ready) begin
          wr      = 1'b1;
          new_res = prod[WIDTH-1:0];
          new_v   = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A result written this edge wins over the output transfer.
    if (wr) begin
      res_d  = new_res;
      neg_d  = new_res[WIDTH-1];
      zero_d = (new_res == '0);
      ovf_d  = new_v;
      cout_d = new_c;
      ov_d   = 1'b1;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      res_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      res_q    <= res_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed bench for alu_seq at WIDTH 64 and 8,
// checked against a signed/unsigned arithmetic model of the op set.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v64, r64, ov64, ordy64, dir64;
  logic        n64, z64, o64, c64, busy64;
  logic [63:0] a64, b64, res64;
  logic [2:0]  op64;

  logic        v8, r8, ov8, ordy8, dir8;
  logic        n8, z8, o8, c8, busy8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;

  alu_seq #(.WIDTH(64)) u64 (
    .clk(clk), .reset_n(rst_n),
    .in_valid(v64), .in_ready(r64),
    .A(a64), .B(b64), .cntrl(op64), .shiftdir(dir64),
    .out_valid(ov64), .out_ready(ordy64), .result(res64),
    .negative(n64), .zero(z64), .overflow(o64),
    .carry_out(c64), .busy(busy64)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(rst_n),
    .in_valid(v8), .in_ready(r8),
    .A(a8), .B(b8), .cntrl(op8), .shiftdir(dir8),
    .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .negative(n8), .zero(z8), .overflow(o8),
    .carry_out(c8), .busy(busy8)
  );

  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int omode64 = 0;
  int omode8 = 0;
  exp_t q64[$];
  exp_t q8[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] sx(input logic [127:0] x, input int w);
    logic [127:0] m;
    logic [127:0] y;
    m = (128'd1 << w) - 128'd1;
    y = x & m;
    return y[w-1] ? (y | ~m) : y;
  endfunction

  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [63:0] ai, input logic [63:0] bi,
                                 input logic dir);
    logic [127:0] m, a, b, r, full, sa, sb;
    int d;
    exp_t e;
    m  = (128'd1 << w) - 128'd1;
    a  = {64'd0, ai} & m;
    b  = {64'd0, bi} & m;
    sa = sx(a, w);
    sb = sx(b, w);
    e  = '0;
    r  = '0;
    d  = int'(b[5:0]) % w;
    case (op)
      3'd0: r = b;
      3'd1: r = dir ? (a >> d) : ((a << d) & m);
      3'd2: begin
        full = a + b;
        r    = full & m;
        e.c  = full[w];
        e.v  = sx(r, w) != (sa + sb);
      end
      3'd3: begin
        full = a + (~b & m) + 128'd1;
        r    = full & m;
        e.c  = full[w];
        e.v  = sx(r, w) != (sa - sb);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: begin
        full = sa * sb;
        r    = full & m;
        e.v  = sx(r, w) != full;
      end
    endcase
    e.r = r[63:0];
    e.n = r[w-1];
    e.z = (r == 128'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q64.delete();
    end else begin
      if (ov64) begin
        if (q64.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL m64_spurious: out_valid=1 with no op pending");
        end else begin
          chk("m64_out", 128'({res64, n64, z64, o64, c64}), 128'(q64[0]));
          if (ordy64) void'(q64.pop_front());
        end
      end
      if (v64 && r64) q64.push_back(model(64, op64, a64, b64, dir64));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (ov8) begin
        if (q8.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL m8_spurious: out_valid=1 with no op pending");
        end else begin
          chk("m8_out", 128'({56'd0, res8, n8, z8, o8, c8}), 128'(q8[0]));
          if (ordy8) void'(q8.pop_front());
        end
      end
      if (v8 && r8) q8.push_back(model(8, op8, {56'd0, a8}, {56'd0, b8}, dir8));
    end
  end

  initial begin
    ordy64 = 1'b1;
    ordy8  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ordy64 = (omode64 == 0) ? 1'b1 : (omode64 == 1) ? 1'b0
             : ($urandom_range(0, 3) != 0);
      ordy8  = (omode8 == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send64(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic dir);
    int n;
    n = 0;
    v64 = 1'b1; op64 = op; a64 = a; b64 = b; dir64 = dir;
    @(negedge clk);
    while (!r64 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!r64) begin
      tests++;
      fails++;
      $display("FAIL send64_timeout: in_ready=0 after %0d clks", n);
    end
    tick();
    v64 = 1'b0;
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
    op64 = 3'($urandom);
    dir64 = 1'($urandom);
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic dir);
    int n;
    n = 0;
    v8 = 1'b1; op8 = op; a8 = a; b8 = b; dir8 = dir;
    @(negedge clk);
    while (!r8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!r8) begin
      tests++;
      fails++;
      $display("FAIL send8_timeout: in_ready=0 after %0d clks", n);
    end
    tick();
    v8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    op8 = 3'($urandom);
    dir8 = 1'($urandom);
  endtask

  task automatic wait_out64();
    int n;
    n = 0;
    while (!ov64 && n < 400) begin
      tick();
      n++;
    end
    if (!ov64) begin
      tests++;
      fails++;
      $display("FAIL wait64_timeout: out_valid=0 after %0d clks", n);
    end
  endtask

  task automatic wait_out8();
    int n;
    n = 0;
    while (!ov8 && n < 400) begin
      tick();
      n++;
    end
    if (!ov8) begin
      tests++;
      fails++;
      $display("FAIL wait8_timeout: out_valid=0 after %0d clks", n);
    end
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 64) ? q64.size() : q8.size()) != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain", 128'((which == 64) ? q64.size() : q8.size()), 128'd0);
  endtask

  task automatic flags64(input string nm, input logic [63:0] r,
                         input logic [3:0] f);
    chk(nm, 128'({res64, n64, z64, o64, c64}), 128'({r, f}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic ok;
    rst_n = 1'b1;
    v64 = 1'b0; a64 = '0; b64 = '0; op64 = '0; dir64 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; dir8 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_state",
        128'({ov64, busy64, r64, res64, n64, z64, o64, c64}),
        128'({3'b001, 64'd0, 4'b0000}));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("pin_add", 128'(model(64, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0)),
        128'({64'h8000_0000_0000_0000, 4'b1010}));
    chk("pin_mul", 128'(model(64, 3'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0)),
        128'({64'hFFFF_FFFF_FFFF_FFEB, 4'b1000}));
    chk("pin_mul8", 128'(model(8, 3'd7, 64'h80, 64'h80, 1'b0)),
        128'({64'h0, 4'b0110}));
    chk("pin_sub", 128'(model(64, 3'd3, 64'd3, 64'd5, 1'b0)),
        128'({64'hFFFF_FFFF_FFFF_FFFE, 4'b1000}));

    send64(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_out64();
    flags64("add_ovf", 64'h8000_0000_0000_0000, 4'b1010);
    send64(3'd3, 64'd5, 64'd5, 1'b0);
    wait_out64();
    flags64("sub_zero", 64'd0, 4'b0101);
    send64(3'd3, 64'd3, 64'd5, 1'b0);
    wait_out64();
    flags64("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    send64(3'd1, 64'd1, 64'd63, 1'b0);
    wait_out64();
    flags64("shl63", 64'h8000_0000_0000_0000, 4'b1000);
    send64(3'd1, 64'd1, 64'd64, 1'b0);
    wait_out64();
    flags64("shl64", 64'd1, 4'b0000);
    send64(3'd1, 64'h8000_0000_0000_0000, 64'd63, 1'b1);
    wait_out64();
    flags64("shr63", 64'd1, 4'b0000);

    send64(3'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0);
    cyc = 0;
    ok = 1'b1;
    while (!ov64 && cyc < 200) begin
      if (r64 !== 1'b0 || busy64 !== 1'b1) ok = 1'b0;
      tick();
      cyc++;
    end
    chk("mul_latency", 128'(cyc), 128'd65);
    chk("mul_inready_low", 128'(ok), 128'd1);
    flags64("mul_neg", 64'hFFFF_FFFF_FFFF_FFEB, 4'b1000);

    @(negedge clk) omode64 = 1;
    tick();
    send64(3'd2, 64'd10, 64'd20, 1'b0);
    repeat (5) begin
      chk("bp_hold", 128'({ov64, r64, res64}), 128'({2'b10, 64'd30}));
      tick();
    end
    @(negedge clk) omode64 = 0;
    repeat (2) tick();

    @(negedge clk) omode64 = 1;
    tick();
    send64(3'd7, 64'd6, 64'd7, 1'b0);
    wait_out64();
    repeat (4) begin
      chk("mul_bp_hold", 128'({ov64, busy64, r64, res64, n64, z64, o64, c64}),
          128'({3'b100, 64'd42, 4'b0000}));
      tick();
    end
    @(negedge clk) omode64 = 0;
    repeat (2) tick();

    send64(3'd7, 64'hFFFF_FFFF_FFFF_FFFB, 64'd9, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mul",
        128'({ov64, busy64, r64, res64, n64, z64, o64, c64}),
        128'({3'b001, 64'd0, 4'b0000}));
    tick();
    rst_n = 1'b1;
    tick();
    send64(3'd2, 64'd2, 64'd3, 1'b0);
    wait_out64();
    flags64("after_reset_add", 64'd5, 4'b0000);
    send64(3'd7, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_out64();
    flags64("mul_zero", 64'd0, 4'b0100);
    tick();

    omode64 = 2;
    for (int i = 0; i < 300; i++) begin
      send64(3'($urandom_range(0, 7)), pick64(), pick64(), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    @(negedge clk) omode64 = 0;
    drain(64);

    send8(3'd7, 8'h80, 8'h80, 1'b0);
    wait_out8();
    chk("mul8_minmin", 128'({res8, n8, z8, o8, c8}), 128'({8'h00, 4'b0110}));
    send8(3'd7, 8'h10, 8'h08, 1'b0);
    wait_out8();
    chk("mul8_ovf", 128'({res8, n8, z8, o8, c8}), 128'({8'h80, 4'b1010}));
    send8(3'd7, 8'h08, 8'h08, 1'b0);
    wait_out8();
    chk("mul8_ok", 128'({res8, n8, z8, o8, c8}), 128'({8'h40, 4'b0000}));
    tick();

    omode8 = 1;
    for (int i = 0; i < 150; i++) begin
      send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk) omode8 = 0;
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
